scanline_buffer: RTL and testbench
==================================

# scanline_buffer

Double-buffered scanline store between the pixel producer (renderer or CPU copy loop) and the VGA timing/colour stage. The producer fills one 256-entry line bank through a valid/ready port while the other bank is read out by pixel x coordinate. Each stored line is shown on LINE_REPEAT consecutive display rows, mapping 240 logical lines onto 480 scan rows. Underruns are repeated, never torn, and flagged.

## Interface
- H_PIXELS, 256: entries per line; must be at most 256.
- V_LINES, 240: logical lines per frame; wr_line wraps at this value.
- LINE_REPEAT, 2: display rows per logical line; must be at least 1.
- CLK12MHz  in  1  pixel clock; the block uses this clock only.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a pixel on wr_data.
- wr_ready  out  1  fill bank accepts a pixel. Transfer happens when wr_valid && wr_ready.
- wr_data  in  9  pixel {r[2:0], g[2:0], b[2:0]}.
- wr_x  out  8  fill address of the next accepted pixel.
- wr_line  out  8  logical line index being filled.
- frame_start  in  1  one-cycle pulse before the first visible row of a frame.
- line_start  in  1  one-cycle pulse before each visible row; always occurs while disp_en=0.
- disp_en  in  1  current pix_x is visible.
- pix_x  in  8  visible column being displayed.
- vga_r, vga_g, vga_b  out  3 each  registered colour output.
- underrun  out  1  sticky flag: a swap was due but the fill bank was not full.

## Operation
- Storage: two banks of H_PIXELS×9 bits.
  - rd_bank selects the display bank; the fill bank is the other one.
  - rd_valid marks the display bank as holding real data.
- Fill state machine, two states:
  - FILL: wr_ready=1. Each transfer writes wr_data to fill[wr_x], then wr_x increments. The transfer at wr_x=H_PIXELS-1 moves to FULL and does not increment wr_x.
  - FULL: wr_ready=0 until a swap.
- Repeat counter rep counts 0..LINE_REPEAT-1.
  - frame_start sets rep=0.
  - Each line_start with rep=0 is a swap point. Every line_start sets rep to rep+1, wrapping to 0 after LINE_REPEAT-1.
- At a swap point:
  - If the fill bank is FULL, or enters FULL in the same cycle: toggle rd_bank, set rd_valid=1, return to FILL with wr_x=0, and set wr_line to wr_line+1 (V_LINES-1 wraps to 0).
  - Otherwise (underrun): no swap; the display bank repeats, underrun is set, and the fill state and wr_x continue unchanged.
- frame_start clears underrun. If frame_start and an underrun occur in the same cycle, underrun ends set.
- Readout: colour = display[pix_x] when disp_en && rd_valid, otherwise 0. pix_x >= H_PIXELS also reads as 0.
- Reset values: rd_bank=0, rd_valid=0, fill state FILL, wr_x=0, wr_line=0, rep=0, underrun=0, vga_r/g/b=0. wr_ready=1 immediately after reset is released. Bank contents are undefined.
- Reset asserted mid-fill or mid-line returns every register above to its reset value asynchronously; partially written data is discarded.

## Timing
- Readout latency is 1 cycle: pix_x and disp_en sampled at edge N produce vga_r/g/b at edge N+1. No combinational path from inputs to outputs.
- A write accepted at edge N is readable after that bank is swapped. A swap at edge N affects readout from edge N+1.
- wr_ready and wr_x are registered. A FULL transition at edge N gives wr_ready=0 from N+1.
- Swap and the final write in the same cycle: the write lands, the swap occurs, and wr_ready stays 1 with wr_x=0 for the new fill bank.
- Sustained fill rate is 1 pixel per clock.

## Test plan
- Reset: hold 5 cycles, release, disp_en=1, pix_x sweep → rgb all 0, wr_ready=1, wr_x=0, wr_line=0, underrun=0.
- Fill and display: write 256 pixels with value wr_x[7:0] → wr_ready=0 after the last; frame_start, line_start, disp_en sweep pix_x=0..255 → rgb one cycle later equals {x[8:6], x[5:3], x[2:0]} (9-bit x), repeated identically on the second row; third line_start with no new data → underrun=1.
- Line doubling and wrap: stream 240 lines, each filled with its line index, across 480 rows → each line shown exactly twice; wr_line wraps 239→0; underrun stays 0.
- Back-pressure: wr_valid held high, next line_start withheld → wr_ready low for the whole wait; no write dropped or duplicated; after the swap, wr_x restarts at 0.
- Coincident final write and swap point in the same cycle → swap occurs, new line displayed on that row, underrun=0.
- Reset mid-fill at wr_x=100 → wr_x=0 and rd_valid=0 (black output) until the next full line is swapped.

Source files
------------

// File: rtl/scanline_buffer.sv
// Double-buffered 9-bit scanline store: the producer fills one bank while the other is read out by pix_x.
// Latency: colour is registered 1 cycle after pix_x/disp_en; wr_ready and wr_x are registered.
// Backpressure: wr_ready drops once the fill bank is full and returns at the next swap point.
module scanline_buffer #(
    parameter int H_PIXELS    = 256,
    parameter int V_LINES     = 240,
    parameter int LINE_REPEAT = 2
) (
    input  logic       CLK12MHz,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [8:0] wr_data,
    output logic [7:0] wr_x,
    output logic [7:0] wr_line,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       disp_en,
    input  logic [7:0] pix_x,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [2:0] vga_b,
    output logic       underrun
);
    localparam int               REP_W     = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
    localparam logic [7:0]       X_LAST    = 8'(H_PIXELS - 1);
    localparam logic [7:0]       LINE_LAST = 8'(V_LINES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(LINE_REPEAT - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    fill_state_t      state;
    fill_state_t      state_nxt;
    logic [7:0]       wr_x_nxt;
    logic [7:0]       wr_line_nxt;
    logic             rd_bank;
    logic             rd_bank_nxt;
    logic             rd_valid;
    logic             rd_valid_nxt;
    logic             underrun_nxt;
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nxt;
    logic             wr_fire;
    logic             last_write;
    logic             swap_point;
    logic             in_range;

    // Two line banks; rd_bank picks the display bank, the other one is being filled.
    logic [8:0] bank [0:1][0:H_PIXELS-1];

    assign wr_ready   = (state == FILL);
    assign wr_fire    = wr_valid && wr_ready;
    assign last_write = wr_fire && (wr_x == X_LAST);
    assign swap_point = line_start && (rep == '0);

    // Columns beyond the stored line read as black.
    if (H_PIXELS < 256) begin : g_range
        assign in_range = (pix_x < 8'(H_PIXELS));
    end else begin : g_full_range
        assign in_range = 1'b1;
    end

    // Pixel store: accepted pixels always land in the bank not being displayed.
    always_ff @(posedge CLK12MHz) begin
        if (wr_fire) begin
            bank[~rd_bank][wr_x] <= wr_data;
        end
    end

    // Registered colour readout; black when blanked, out of range or no line swapped in yet.
    always_ff @(posedge CLK12MHz or posedge reset) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= '0;
        end else if (disp_en && rd_valid && in_range) begin
            {vga_r, vga_g, vga_b} <= bank[rd_bank][pix_x];
        end else begin
            {vga_r, vga_g, vga_b} <= '0;
        end
    end

    // Control registers: fill state, fill address, line index, bank select, repeat count, flags.
    always_ff @(posedge CLK12MHz or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            wr_x     <= '0;
            wr_line  <= '0;
            rd_bank  <= 1'b0;
            rd_valid <= 1'b0;
            rep      <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_x     <= wr_x_nxt;
            wr_line  <= wr_line_nxt;
            rd_bank  <= rd_bank_nxt;
            rd_valid <= rd_valid_nxt;
            rep      <= rep_nxt;
            underrun <= underrun_nxt;
        end
    end

    // Next-state: fill progress, swap or underrun at swap points, row repeat counting.
    always_comb begin
        state_nxt    = state;
        wr_x_nxt     = wr_x;
        wr_line_nxt  = wr_line;
        rd_bank_nxt  = rd_bank;
        rd_valid_nxt = rd_valid;
        underrun_nxt = underrun;
        rep_nxt      = rep;

        // The final write parks wr_x on the last column instead of wrapping.
        if (wr_fire) begin
            if (last_write) begin
                state_nxt = FULL;
            end else begin
                wr_x_nxt = wr_x + 8'd1;
            end
        end

        if (frame_start) begin
            underrun_nxt = 1'b0;
        end

        // A bank completing on this very edge still counts as full, so the swap is not missed.
        if (swap_point) begin
            if ((state == FULL) || last_write) begin
                state_nxt    = FILL;
                wr_x_nxt     = '0;
                wr_line_nxt  = (wr_line == LINE_LAST) ? 8'd0 : wr_line + 8'd1;
                rd_bank_nxt  = ~rd_bank;
                rd_valid_nxt = 1'b1;
            end else begin
                underrun_nxt = 1'b1;
            end
        end

        if (line_start) begin
            rep_nxt = (rep == REP_LAST) ? '0 : rep + 1'b1;
        end
        if (frame_start) begin
            rep_nxt = '0;
        end
    end
endmodule

// File: tb/tb_scanline_buffer.sv
// Randomized bench for scanline_buffer with a line-copy reference model.
// Every negedge compares all outputs against the model; a few literal probes pin the model.
// All waits are bounded; the run ends with one summary line.
module tb_scanline_buffer;
    localparam int H  = 256;
    localparam int V  = 240;
    localparam int LR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_data;
    logic [7:0] wr_x;
    logic [7:0] wr_line;
    logic       frame_start;
    logic       line_start;
    logic       disp_en;
    logic [7:0] pix_x;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [2:0] vga_b;
    logic       underrun;

    int vectors     = 0;
    int miscompares = 0;

    scanline_buffer #(.H_PIXELS(H), .V_LINES(V), .LINE_REPEAT(LR)) dut (
        .CLK12MHz   (clk),
        .reset      (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_x       (wr_x),
        .wr_line    (wr_line),
        .frame_start(frame_start),
        .line_start (line_start),
        .disp_en    (disp_en),
        .pix_x      (pix_x),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Reference model: a line being filled, a copy of the line on screen, row count since frame start.
    logic [8:0] m_fill [H];
    logic [8:0] m_disp [H];
    bit         m_full;
    bit         m_rd_valid;
    bit         m_underrun;
    int         m_wr_x;
    int         m_wr_line;
    int         m_row;
    int         swaps;
    bit         m_last_fire;
    bit         m_last_swap;
    logic [8:0] exp_rgb;
    int         dmode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_full      = 0;
        m_rd_valid  = 0;
        m_underrun  = 0;
        m_wr_x      = 0;
        m_wr_line   = 0;
        m_row       = 0;
        m_last_fire = 0;
        m_last_swap = 0;
        exp_rgb     = '0;
    endtask

    task automatic model_step();
        bit fire;
        fire = wr_valid && !m_full;
        m_last_swap = 0;
        exp_rgb = (disp_en && m_rd_valid && int'(pix_x) < H) ? m_disp[pix_x] : 9'd0;
        if (fire) begin
            m_fill[m_wr_x] = wr_data;
            if (m_wr_x == H - 1) m_full = 1;
            else m_wr_x++;
        end
        if (frame_start) m_underrun = 0;
        if (line_start) begin
            if (m_row % LR == 0) begin
                if (m_full) begin
                    m_disp      = m_fill;
                    m_rd_valid  = 1;
                    m_full      = 0;
                    m_wr_x      = 0;
                    m_wr_line   = (m_wr_line + 1) % V;
                    swaps++;
                    m_last_swap = 1;
                end else begin
                    m_underrun = 1;
                end
            end
            m_row++;
        end
        if (frame_start) m_row = 0;
        m_last_fire = fire;
    endtask

    function automatic logic [8:0] gen();
        case (dmode)
            0:       return 9'(m_wr_x);
            1:       return 9'(m_wr_line);
            default: return 9'($urandom);
        endcase
    endfunction

    // One clock: model advances on the edge, producer presents its next pixel just after.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        if (m_last_fire || m_last_swap) wr_data = gen();
    endtask

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        check("wr_ready", 32'(wr_ready), 32'(!m_full));
        check("wr_x", 32'(wr_x), 32'(m_wr_x));
        check("wr_line", 32'(wr_line), 32'(m_wr_line));
        check("underrun", 32'(underrun), 32'(m_underrun));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    end

    task automatic pulse_frame();
        disp_en = 0;
        frame_start = 1;
        cycle();
        frame_start = 0;
    endtask

    task automatic pulse_line();
        disp_en = 0;
        line_start = 1;
        cycle();
        line_start = 0;
    endtask

    task automatic sweep(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            disp_en = 1;
            pix_x = rnd ? 8'($urandom) : 8'(i);
            cycle();
        end
        disp_en = 0;
    endtask

    task automatic probe(input string name, input logic [7:0] x, input logic [8:0] exp);
        disp_en = 1;
        pix_x = x;
        cycle();
        disp_en = 0;
        check(name, 32'({vga_r, vga_g, vga_b}), 32'(exp));
    endtask

    task automatic fill_until_full();
        int n;
        n = 0;
        wr_valid = 1;
        while (!m_full && n < 600) begin
            cycle();
            n++;
        end
        if (!m_full) timeout("fill_wait");
    endtask

    initial begin
        int s0;
        int n;
        rst = 1; wr_valid = 0; wr_data = '0; frame_start = 0; line_start = 0;
        disp_en = 0; pix_x = '0; dmode = 0; swaps = 0;
        model_reset();

        // Reset and black readout
        repeat (5) cycle();
        rst = 0;
        sweep(256, 0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_wr_x", 32'(wr_x), 32'd0);
        check("rst_wr_line", 32'(wr_line), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);

        // Fill with x, show twice, then underrun on the third row
        dmode = 0;
        wr_data = gen();
        fill_until_full();
        wr_valid = 0;
        cycle();
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_wr_x", 32'(wr_x), 32'd255);
        pulse_frame();
        pulse_line();
        sweep(256, 0);
        probe("row1_px77", 8'd77, 9'd77);
        probe("row1_px255", 8'd255, 9'd255);
        pulse_line();
        sweep(256, 0);
        probe("row2_px77", 8'd77, 9'd77);
        probe("row2_px200", 8'd200, 9'd200);
        pulse_line();
        check("underrun_set", 32'(underrun), 32'd1);
        probe("underrun_repeat_px5", 8'd5, 9'd5);

        // 240 lines over 480 rows at full rate, line index as data
        dmode = 1;
        wr_data = gen();
        fill_until_full();
        s0 = swaps;
        pulse_frame();
        for (int row = 0; row < 2 * V; row++) begin
            pulse_line();
            sweep(128, 1);
        end
        check("frame_swaps", 32'(swaps - s0), 32'd240);
        check("frame_wr_line_wrapped", 32'(wr_line), 32'd1);
        check("frame_underrun", 32'(underrun), 32'd0);

        // Back-pressure: valid held high while the swap is withheld
        dmode = 2;
        pulse_frame();
        pulse_line();
        wr_data = gen();
        fill_until_full();
        pulse_line();
        repeat (40) cycle();
        check("bp_wr_ready_low", 32'(wr_ready), 32'd0);
        pulse_line();
        check("bp_wr_x_restart", 32'(wr_x), 32'd0);
        check("bp_wr_ready_back", 32'(wr_ready), 32'd1);
        wr_valid = 0;
        sweep(256, 0);

        // Final write coincident with the swap point
        pulse_frame();
        wr_data = gen();
        wr_valid = 1;
        n = 0;
        while (m_wr_x != 255 && n < 600) begin
            cycle();
            n++;
        end
        if (m_wr_x != 255) timeout("coinc_wait");
        line_start = 1;
        cycle();
        line_start = 0;
        wr_valid = 0;
        check("coinc_wr_ready", 32'(wr_ready), 32'd1);
        check("coinc_wr_x", 32'(wr_x), 32'd0);
        check("coinc_underrun", 32'(underrun), 32'd0);
        sweep(256, 0);

        // Reset in the middle of a fill
        wr_data = gen();
        wr_valid = 1;
        n = 0;
        while (m_wr_x != 100 && n < 600) begin
            cycle();
            n++;
        end
        if (m_wr_x != 100) timeout("midfill_wait");
        rst = 1;
        model_reset();
        repeat (3) cycle();
        rst = 0;
        wr_valid = 0;
        check("midrst_wr_x", 32'(wr_x), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        check("midrst_wr_line", 32'(wr_line), 32'd0);
        sweep(64, 1);
        probe("midrst_black", 8'd100, 9'd0);
        wr_data = gen();
        fill_until_full();
        wr_valid = 0;
        pulse_frame();
        pulse_line();
        sweep(256, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
